hazard_scoreboard: RTL and testbench

Parametrised successor to the single-cycle load-use detector. Tracks every in-flight long-latency producer (loads with configurable memory latency, multi-cycle MDU ops with writeback handshake) in a per-register scoreboard. Raises a decode-stage stall on RAW, WAW and MDU-structural hazards. Sits beside the ID stage; drives the IF/ID hold and the ID/EX bubble insertion.

---
 rtl/hazard_scoreboard_pkg.sv | 17 +
 rtl/hazard_scoreboard_reg_entry.sv | 38 +++
 rtl/hazard_scoreboard.sv | 132 +++++++++++++
 tb/tb_hazard_scoreboard.sv | 404 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hazard_scoreboard_pkg.sv
// Shared types for the hazard scoreboard: register address width and stall-cause encoding.
package hazard_pkg;

  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [1:0] {
    CAUSE_NONE   = 2'b00,
    CAUSE_LOAD   = 2'b01,
    CAUSE_MDU    = 2'b10,
    CAUSE_STRUCT = 2'b11
  } cause_t;

  function automatic logic [31:0] sat_inc32(input logic [31:0] v);
    return (&v) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/hazard_scoreboard_reg_entry.sv
// One architectural register's scoreboard entry: load countdown plus MDU-pending flag.
module hazard_reg_entry #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned LOAD_LAT = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic load_set,
  input  logic mdu_set,
  input  logic mdu_clr,
  output logic load_busy,
  output logic mdu_busy
);

  logic [CNT_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt      <= '0;
      mdu_busy <= 1'b0;
    end else begin
      // A fresh load wins over this cycle's decrement.
      if (load_set) begin
        cnt <= CNT_W'(LOAD_LAT + 1);
      end else if (cnt != '0) begin
        cnt <= cnt - 1'b1;
      end
      if (mdu_set) begin
        mdu_busy <= 1'b1;
      end else if (mdu_clr) begin
        mdu_busy <= 1'b0;
      end
    end
  end

  assign load_busy = (cnt != '0);

endmodule

// File: rtl/hazard_scoreboard.sv
// Per-register hazard scoreboard beside ID: stalls on load-use, MDU RAW/WAW and MDU structural hazards.
// Optional stall statistics counters are enabled with `define HAZARD_STATS_EN.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int unsigned NUM_REGS  = 32,
  parameter int unsigned LOAD_LAT  = 0,
  parameter int unsigned MDU_DEPTH = 1,
  parameter int unsigned CNT_W     = 3
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             id_valid,
  input  logic [REG_ADDR_W-1:0]            id_rs1,
  input  logic [REG_ADDR_W-1:0]            id_rs2,
  input  logic                             id_rs1_used,
  input  logic                             id_rs2_used,
  input  logic [REG_ADDR_W-1:0]            id_rd,
  input  logic                             id_reg_write,
  input  logic                             id_is_load,
  input  logic                             id_is_mdu,
  input  logic                             flush,
  input  logic                             mdu_wb_valid,
  input  logic [REG_ADDR_W-1:0]            mdu_wb_rd,
  output logic                             stall,
  output logic                             issue,
  output logic [1:0]                       stall_cause,
  output logic [NUM_REGS-1:0]              busy_vec,
  output logic [$clog2(MDU_DEPTH+1)-1:0]   mdu_pending
`ifdef HAZARD_STATS_EN
  ,
  output logic [31:0]                      stat_load_stalls,
  output logic [31:0]                      stat_mdu_stalls
`endif
);

  localparam int unsigned PEND_W = $clog2(MDU_DEPTH + 1);

  logic [NUM_REGS-1:0] load_busy_vec;
  logic [NUM_REGS-1:0] mdu_busy_vec;
  logic                wr_en;
  logic                wr_load;
  logic                wr_mdu;
  logic                rd_chk;
  logic                haz_load;
  logic                haz_mdu;
  logic                haz_struct;
  logic                wb_hit;
  cause_t              cause;

  assign load_busy_vec[0] = 1'b0;
  assign mdu_busy_vec[0]  = 1'b0;

  assign wr_en   = issue & id_reg_write & (id_rd != '0);
  assign wr_load = wr_en & id_is_load;
  assign wr_mdu  = wr_en & id_is_mdu & ~id_is_load;

  for (genvar r = 1; r < NUM_REGS; r++) begin : g_entry
    hazard_reg_entry #(
      .CNT_W    (CNT_W),
      .LOAD_LAT (LOAD_LAT)
    ) u_entry (
      .clk       (clk),
      .rst       (rst),
      .load_set  (wr_load & (id_rd == REG_ADDR_W'(r))),
      .mdu_set   (wr_mdu & (id_rd == REG_ADDR_W'(r))),
      .mdu_clr   (mdu_wb_valid & (mdu_wb_rd == REG_ADDR_W'(r))),
      .load_busy (load_busy_vec[r]),
      .mdu_busy  (mdu_busy_vec[r])
    );
  end

  assign busy_vec = load_busy_vec | mdu_busy_vec;

  // WAW classifies by the kind of entry pending on id_rd; bit 0 of both vectors is tied low.
  assign rd_chk     = id_reg_write & (id_rd != '0);
  assign haz_load   = (id_rs1_used & load_busy_vec[id_rs1])
                    | (id_rs2_used & load_busy_vec[id_rs2])
                    | (rd_chk      & load_busy_vec[id_rd]);
  assign haz_mdu    = (id_rs1_used & mdu_busy_vec[id_rs1])
                    | (id_rs2_used & mdu_busy_vec[id_rs2])
                    | (rd_chk      & mdu_busy_vec[id_rd]);
  assign haz_struct = id_is_mdu & (mdu_pending == PEND_W'(MDU_DEPTH));

  always_comb begin
    cause = CAUSE_NONE;
    stall = 1'b0;
    issue = 1'b0;
    if (id_valid && !flush) begin
      if (haz_load) begin
        cause = CAUSE_LOAD;
      end else if (haz_mdu) begin
        cause = CAUSE_MDU;
      end else if (haz_struct) begin
        cause = CAUSE_STRUCT;
      end
      stall = (cause != CAUSE_NONE);
      issue = ~stall;
    end
  end

  assign stall_cause = cause;

  // Only a writeback that actually retires a pending entry frees an MDU slot.
  assign wb_hit = mdu_wb_valid & mdu_busy_vec[mdu_wb_rd];

  always_ff @(posedge clk) begin
    if (rst) begin
      mdu_pending <= '0;
    end else if (wr_mdu && !wb_hit) begin
      mdu_pending <= mdu_pending + 1'b1;
    end else if (wb_hit && !wr_mdu) begin
      mdu_pending <= mdu_pending - 1'b1;
    end
  end

`ifdef HAZARD_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      stat_load_stalls <= '0;
      stat_mdu_stalls  <= '0;
    end else if (stall) begin
      if (cause == CAUSE_LOAD) begin
        stat_load_stalls <= sat_inc32(stat_load_stalls);
      end else begin
        stat_mdu_stalls <= sat_inc32(stat_mdu_stalls);
      end
    end
  end
`endif

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Bench for hazard_scoreboard: two instances (LOAD_LAT=0/MDU_DEPTH=1 and LOAD_LAT=2/MDU_DEPTH=2) on shared inputs.
module tb_hazard_scoreboard;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, id_valid, id_rs1_used, id_rs2_used, id_reg_write, id_is_load, id_is_mdu;
  logic       flush, mdu_wb_valid;
  logic [4:0] id_rs1, id_rs2, id_rd, mdu_wb_rd;

  logic        s0, i0, s1, i1;
  logic [1:0]  c0, c1;
  logic [31:0] b0, b1;
  logic [0:0]  p0;
  logic [1:0]  p1;
`ifdef HAZARD_STATS_EN
  logic [31:0] sl0, sm0, sl1, sm1;
`endif

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(0), .MDU_DEPTH(1), .CNT_W(3)) dut0 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .flush(flush), .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
    .stall(s0), .issue(i0), .stall_cause(c0), .busy_vec(b0), .mdu_pending(p0)
`ifdef HAZARD_STATS_EN
    , .stat_load_stalls(sl0), .stat_mdu_stalls(sm0)
`endif
  );

  hazard_scoreboard #(.NUM_REGS(32), .LOAD_LAT(2), .MDU_DEPTH(2), .CNT_W(3)) dut2 (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_rs1(id_rs1), .id_rs2(id_rs2),
    .id_rs1_used(id_rs1_used), .id_rs2_used(id_rs2_used), .id_rd(id_rd),
    .id_reg_write(id_reg_write), .id_is_load(id_is_load), .id_is_mdu(id_is_mdu),
    .flush(flush), .mdu_wb_valid(mdu_wb_valid), .mdu_wb_rd(mdu_wb_rd),
    .stall(s1), .issue(i1), .stall_cause(c1), .busy_vec(b1), .mdu_pending(p1)
`ifdef HAZARD_STATS_EN
    , .stat_load_stalls(sl1), .stat_mdu_stalls(sm1)
`endif
  );

  // Observation word: {stall, issue, cause[1:0], busy[31:0], pending[1:0]}
  logic [37:0] obs [2];
  assign obs[0] = {s0, i0, c0, b0, 1'b0, p0};
  assign obs[1] = {s1, i1, c1, b1, p1};

  // Reference model: loads tracked as "first cycle the result is usable", MDU as a pending set.
  int          lat   [2] = '{0, 2};
  int          depth [2] = '{1, 2};
  longint      cyc;
  longint      ready [2][32];
  bit          mp    [2][32];
  int          pend  [2];
  int          stl   [2];
  int          stm   [2];
  logic [37:0] exp_v [2];
  bit          e_stall [2];
  bit          e_issue [2];
  logic [1:0]  e_cause [2];
  int          n_chk, n_fail;

  function automatic bit ldb(int i, int r);
    return (r != 0) && (cyc < ready[i][r]);
  endfunction

  function automatic void model_eval();
    for (int i = 0; i < 2; i++) begin
      bit hl, hm, hs;
      logic [31:0] bv;
      int r1, r2, rd;
      r1 = int'(id_rs1); r2 = int'(id_rs2); rd = int'(id_rd);
      hl = (id_rs1_used && ldb(i, r1)) || (id_rs2_used && ldb(i, r2)) ||
           (id_reg_write && rd != 0 && ldb(i, rd));
      hm = (id_rs1_used && mp[i][r1]) || (id_rs2_used && mp[i][r2]) ||
           (id_reg_write && rd != 0 && mp[i][rd]);
      hs = id_is_mdu && (pend[i] == depth[i]);
      e_stall[i] = id_valid && !flush && (hl || hm || hs);
      e_issue[i] = id_valid && !flush && !(hl || hm || hs);
      e_cause[i] = !e_stall[i] ? 2'd0 : hl ? 2'd1 : hm ? 2'd2 : 2'd3;
      bv = '0;
      for (int r = 1; r < 32; r++) bv[r] = ldb(i, r) || mp[i][r];
      exp_v[i] = {e_stall[i], e_issue[i], e_cause[i], bv, 2'(pend[i])};
    end
  endfunction

  function automatic void model_commit();
    for (int i = 0; i < 2; i++) begin
      if (rst) begin
        for (int r = 0; r < 32; r++) begin
          ready[i][r] = 0;
          mp[i][r]    = 1'b0;
        end
        pend[i] = 0; stl[i] = 0; stm[i] = 0;
      end else begin
        if (e_stall[i]) begin
          if (e_cause[i] == 2'd1) stl[i]++;
          else stm[i]++;
        end
        if (mdu_wb_valid && mdu_wb_rd != 0 && mp[i][mdu_wb_rd]) begin
          mp[i][mdu_wb_rd] = 1'b0;
          pend[i]--;
        end
        if (e_issue[i] && id_reg_write && id_rd != 0) begin
          if (id_is_load) ready[i][id_rd] = cyc + lat[i] + 2;
          else if (id_is_mdu) begin
            mp[i][id_rd] = 1'b1;
            pend[i]++;
          end
        end
      end
    end
    cyc++;
  endfunction

  task automatic settle();
    #1;
    model_eval();
  endtask

  task automatic step();
    model_eval();
    @(posedge clk);
    model_commit();
    @(negedge clk);
  endtask

  task automatic set_idle();
    rst = 1'b0; id_valid = 1'b0; id_rs1 = '0; id_rs2 = '0; id_rs1_used = 1'b0;
    id_rs2_used = 1'b0; id_rd = '0; id_reg_write = 1'b0; id_is_load = 1'b0;
    id_is_mdu = 1'b0; flush = 1'b0; mdu_wb_valid = 1'b0; mdu_wb_rd = '0;
  endtask

  task automatic drive(input bit v, input int rs1, input bit u1, input int rs2, input bit u2,
                       input int rd, input bit rw, input bit ld, input bit md);
    id_valid = v; id_rs1 = 5'(rs1); id_rs1_used = u1; id_rs2 = 5'(rs2); id_rs2_used = u2;
    id_rd = 5'(rd); id_reg_write = rw; id_is_load = ld; id_is_mdu = md; flush = 1'b0;
  endtask

  task automatic do_reset();
    set_idle();
    rst = 1'b1;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    set_idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
    settle();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_model dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
      end
      n_chk++;
      if (obs[i] !== {2'b01, 36'h0}) begin
        n_fail++;
        $display("FAIL reset_state dut%0d act=%h exp=%h", i, obs[i], {2'b01, 36'h0});
      end
    end
`ifdef HAZARD_STATS_EN
    n_chk++;
    if ({sl0, sm0, sl1, sm1} !== 128'h0) begin
      n_fail++;
      $display("FAIL reset_stats act=%h exp=0", {sl0, sm0, sl1, sm1});
    end
`endif
    step();
  endtask

  task automatic test_load_use();
    // {reg, via_rs2, used, stalls for LOAD_LAT=0, stalls for LOAD_LAT=2}
    int tab [3][5] = '{'{5, 1, 1, 1, 3}, '{7, 0, 1, 1, 3}, '{7, 0, 0, 0, 0}};
    for (int s = 0; s < 3; s++) begin
      int  ns [2];
      bit  done [2];
      int  rg;
      ns = '{0, 0}; done = '{0, 0}; rg = tab[s][0];
      drive(1, 0, 0, 0, 0, rg, 1, 1, 0);
      settle();
      step();
      if (tab[s][1] == 1) drive(1, 0, 0, rg, tab[s][2] != 0, 6, 1, 0, 0);
      else                drive(1, rg, tab[s][2] != 0, 0, 0, 6, 1, 0, 0);
      for (int k = 0; k < 6; k++) begin
        settle();
        for (int i = 0; i < 2; i++) begin
          n_chk++;
          if (obs[i] !== exp_v[i]) begin
            n_fail++;
            $display("FAIL load_use dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
          end
          if (!done[i]) begin
            if (obs[i][37]) ns[i]++;
            if (obs[i][36]) done[i] = 1'b1;
          end
        end
        step();
      end
      set_idle();
      settle();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (ns[i] !== tab[s][3+i] || !done[i] || obs[i][2+rg] !== 1'b0) begin
          n_fail++;
          $display("FAIL load_use_count dut%0d scen%0d act=%0d/%0d/%b exp=%0d/1/0",
                   i, s, ns[i], done[i], obs[i][2+rg], tab[s][3+i]);
        end
      end
      step();
    end
  endtask

  task automatic test_mdu_raw();
    do_reset();
    drive(1, 0, 0, 0, 0, 9, 1, 0, 1);
    settle();
    step();
    drive(1, 9, 1, 0, 0, 14, 1, 0, 0);
    for (int k = 0; k < 6; k++) begin
      mdu_wb_valid = (k == 2) || (k == 5);
      mdu_wb_rd    = (k == 2) ? 5'd12 : 5'd9;
      settle();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_v[i] || obs[i][37:34] !== 4'b1010) begin
          n_fail++;
          $display("FAIL mdu_raw dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
        end
      end
      step();
    end
    mdu_wb_valid = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs[i] !== exp_v[i] || obs[i][36] !== 1'b1) begin
        n_fail++;
        $display("FAIL mdu_raw_issue dut%0d act=%h exp=%h", i, obs[i], exp_v[i]);
      end
    end
    step();
    set_idle();
  endtask

  task automatic test_struct();
    do_reset();
    for (int c = 0; c < 6; c++) begin
      case (c)
        0: drive(1, 0, 0, 0, 0, 10, 1, 0, 1);
        1: drive(1, 0, 0, 0, 0, 11, 1, 0, 1);
        2: begin mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd10; end
        3: mdu_wb_valid = 1'b0;
        4: begin drive(1, 0, 0, 0, 0, 12, 1, 0, 1); mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd11; end
        default: set_idle();
      endcase
      settle();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL struct dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
        end
      end
      n_chk++;
      if (c inside {1, 2, 4} && obs[0][37:34] !== 4'b1011) begin
        n_fail++;
        $display("FAIL struct_cause c%0d act=%b exp=1011", c, obs[0][37:34]);
      end else if (c == 3 && obs[0][36] !== 1'b1) begin
        n_fail++;
        $display("FAIL struct_issue act=%b exp=1", obs[0][36]);
      end else if (c == 5 && {obs[0][1:0], obs[1][1:0]} !== 4'b0001) begin
        n_fail++;
        $display("FAIL struct_pend act=%b exp=0001", {obs[0][1:0], obs[1][1:0]});
      end
      step();
    end
  endtask

  task automatic test_corner();
    do_reset();
    for (int c = 0; c < 8; c++) begin
      case (c)
        0: drive(1, 0, 0, 0, 0, 0, 1, 1, 0);
        1: drive(1, 0, 1, 0, 1, 0, 1, 0, 0);
        2: drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        3: drive(1, 0, 0, 0, 0, 3, 1, 1, 0);
        4: begin drive(1, 0, 0, 0, 0, 3, 1, 1, 0); flush = 1'b1; end
        5: begin set_idle(); mdu_wb_valid = 1'b1; mdu_wb_rd = 5'd0; end
        default: set_idle();
      endcase
      settle();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL corner dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
        end
        n_chk++;
        if ((c == 1 && obs[i][37:36] !== 2'b01) ||
            (c == 3 && obs[i][37:34] !== 4'b1001) ||
            (c == 4 && obs[i][37:34] !== 4'b0000)) begin
          n_fail++;
          $display("FAIL corner_fixed dut%0d c%0d act=%b", i, c, obs[i][37:34]);
        end
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    drive(1, 0, 0, 0, 0, 1, 1, 1, 0); step();
    drive(1, 0, 0, 0, 0, 2, 1, 1, 0); step();
    drive(1, 0, 0, 0, 0, 4, 1, 0, 1); step();
    drive(1, 4, 1, 0, 0, 8, 1, 0, 0);
    rst = 1'b1;
    settle();
    n_chk++;
    if (obs[1][33:2] !== 32'h16 || obs[0][33:2] !== 32'h10 || obs[1] !== exp_v[1]) begin
      n_fail++;
      $display("FAIL reset_mid_pre act=%h/%h exp busy=16/10", obs[1][33:2], obs[0][33:2]);
    end
    step();
    rst = 1'b0;
    settle();
    for (int i = 0; i < 2; i++) begin
      n_chk++;
      if (obs[i] !== {2'b01, 36'h0} || obs[i] !== exp_v[i]) begin
        n_fail++;
        $display("FAIL reset_mid dut%0d act=%h exp=%h", i, obs[i], {2'b01, 36'h0});
      end
    end
    step();
    set_idle();
  endtask

  task automatic test_random();
    do_reset();
    for (int k = 0; k < 400; k++) begin
      int kind;
      kind = $urandom_range(0, 5);
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 7), $urandom_range(0, 1) != 0,
            $urandom_range(0, 7), $urandom_range(0, 1) != 0, $urandom_range(0, 7),
            $urandom_range(0, 4) != 0, kind < 2, kind == 2);
      flush        = ($urandom_range(0, 9) == 0);
      rst          = ($urandom_range(0, 63) == 0);
      mdu_wb_valid = ($urandom_range(0, 1) != 0);
      mdu_wb_rd    = 5'($urandom_range(0, 7));
      settle();
      for (int i = 0; i < 2; i++) begin
        n_chk++;
        if (obs[i] !== exp_v[i]) begin
          n_fail++;
          $display("FAIL random dut%0d cyc=%0d act=%h exp=%h", i, cyc, obs[i], exp_v[i]);
        end
      end
      step();
    end
    set_idle();
  endtask

`ifdef HAZARD_STATS_EN
  task automatic test_stats();
    settle();
    n_chk++;
    if ({sl0, sm0, sl1, sm1} !== {32'(stl[0]), 32'(stm[0]), 32'(stl[1]), 32'(stm[1])}) begin
      n_fail++;
      $display("FAIL stats act=%0d/%0d/%0d/%0d exp=%0d/%0d/%0d/%0d",
               sl0, sm0, sl1, sm1, stl[0], stm[0], stl[1], stm[1]);
    end
  endtask
`endif

  initial begin
    n_chk = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 2; i++) begin
      pend[i] = 0; stl[i] = 0; stm[i] = 0;
      for (int r = 0; r < 32; r++) begin ready[i][r] = 0; mp[i][r] = 1'b0; end
    end
    set_idle();
    @(negedge clk);
    test_reset();
    test_load_use();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    test_mdu_raw();
    test_struct();
    test_corner();
    test_reset_mid();
    test_random();
`ifdef HAZARD_STATS_EN
    test_stats();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
